// File: rtl/cordic_pipe_if.sv
// cordic_pipe_if: sample handshake bundle for cordic_pipe.
// master drives i_* (upstream + downstream ready), slave is the engine.
interface cordic_pipe_if #(
   parameter int WIDTH = 20
);
   logic                    i_in_valid;
   logic                    o_in_ready;
   logic                    i_vectoring_mode;
   logic signed [WIDTH-1:0] i_X;
   logic signed [WIDTH-1:0] i_Y;
   logic                    o_out_valid;
   logic                    i_out_ready;
   logic                    o_vectoring_mode;
   logic signed [WIDTH-1:0] o_X;
   logic signed [WIDTH-1:0] o_Y;

   modport master (
      output i_in_valid, i_vectoring_mode,
      output i_X, i_Y, i_out_ready,
      input  o_in_ready, o_out_valid,
      input  o_vectoring_mode, o_X, o_Y
   );

   modport slave (
      input  i_in_valid, i_vectoring_mode,
      input  i_X, i_Y, i_out_ready,
      output o_in_ready, o_out_valid,
      output o_vectoring_mode, o_X, o_Y
   );
endinterface

// File: rtl/cordic_pipe.sv
// cordic_pipe: pipelined vectoring/rotation CORDIC, one stage per iter.
// Ports: Clk, Reset_n (async low), bus (cordic_pipe_if.slave).
// Macro CORDIC_GAIN_COMP_EN adds a K=0.607239 scaling stage.
module cordic_pipe #(
   parameter int WIDTH  = 20,
   parameter int STAGES = 16
) (
   input logic          Clk,
   input logic          Reset_n,
   cordic_pipe_if.slave bus
);

   localparam int W = WIDTH + 2;
   typedef logic signed [W-1:0]     dw_t;
   typedef logic signed [WIDTH-1:0] ow_t;

   localparam dw_t SAT_MAX =
      dw_t'({3'b000, {(WIDTH-1){1'b1}}});
   localparam dw_t SAT_MIN =
      dw_t'({3'b111, {(WIDTH-1){1'b0}}});

   function automatic ow_t sat(input dw_t v);
      if (v > SAT_MAX) return ow_t'(SAT_MAX[WIDTH-1:0]);
      if (v < SAT_MIN) return ow_t'(SAT_MIN[WIDTH-1:0]);
      return ow_t'(v[WIDTH-1:0]);
   endfunction

   logic stall;
   logic o_v_q;
   logic o_m_q;
   ow_t  o_x_q;
   ow_t  o_y_q;

   assign stall                = o_v_q & ~bus.i_out_ready;
   assign bus.o_in_ready       = ~stall;
   assign bus.o_out_valid      = o_v_q;
   assign bus.o_vectoring_mode = o_m_q;
   assign bus.o_X              = o_x_q;
   assign bus.o_Y              = o_y_q;

   // pre-rotation stage
   dw_t  in_x, in_y;
   dw_t  p_x_d, p_y_d;
   dw_t  p_x_q, p_y_q;
   logic p_v_q, p_m_q;
   logic neg;
   logic rot_flag_d, rot_flag_q;

   always_comb begin
      in_x = {{2{bus.i_X[WIDTH-1]}}, bus.i_X};
      in_y = {{2{bus.i_Y[WIDTH-1]}}, bus.i_Y};
      neg  = bus.i_vectoring_mode ? in_x[W-1]
                                  : rot_flag_q;
      p_x_d = neg ? -in_x : in_x;
      p_y_d = neg ? -in_y : in_y;
      rot_flag_d = rot_flag_q;
      if (bus.i_in_valid & bus.i_vectoring_mode)
         rot_flag_d = in_x[W-1];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         p_v_q      <= 1'b0;
         p_m_q      <= 1'b0;
         p_x_q      <= '0;
         p_y_q      <= '0;
         rot_flag_q <= 1'b0;
      end else if (!stall) begin
         p_v_q      <= bus.i_in_valid;
         p_m_q      <= bus.i_vectoring_mode;
         p_x_q      <= p_x_d;
         p_y_q      <= p_y_d;
         rot_flag_q <= rot_flag_d;
      end
   end

   // micro-rotation stages; s*[i] is the input to stage i
   dw_t               sx [STAGES+1];
   dw_t               sy [STAGES+1];
   logic [STAGES:0]   sv, sm;
   dw_t               x_d [STAGES];
   dw_t               y_d [STAGES];
   dw_t               x_q [STAGES];
   dw_t               y_q [STAGES];
   logic [STAGES-1:0] v_q, m_q;
   logic [STAGES-1:0] dir_d, dir_q;
   logic [STAGES-1:0] dir_v;

   assign sv = {v_q, p_v_q};
   assign sm = {m_q, p_m_q};

   always_comb begin
      sx[0] = p_x_q;
      sy[0] = p_y_q;
      for (int i = 0; i < STAGES; i++) begin
         sx[i+1] = x_q[i];
         sy[i+1] = y_q[i];
      end
      dir_v = '0;
      dir_d = dir_q;
      for (int i = 0; i < STAGES; i++) begin
         // vectoring: rotate clockwise while Y>0
         if (sm[i])
            dir_v[i] = ~sy[i][W-1] & (|sy[i]);
         else
            dir_v[i] = dir_q[i];
         if (sv[i] & sm[i])
            dir_d[i] = dir_v[i];
         if (dir_v[i]) begin
            x_d[i] = sx[i] + (sy[i] >>> i);
            y_d[i] = sy[i] - (sx[i] >>> i);
         end else begin
            x_d[i] = sx[i] - (sy[i] >>> i);
            y_d[i] = sy[i] + (sx[i] >>> i);
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         v_q   <= '0;
         m_q   <= '0;
         dir_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
      end else if (!stall) begin
         v_q   <= sv[STAGES-1:0];
         m_q   <= sm[STAGES-1:0];
         dir_q <= dir_d;
         x_q   <= x_d;
         y_q   <= y_d;
      end
   end

   dw_t  f_x, f_y;
   logic f_v, f_m;

`ifdef CORDIC_GAIN_COMP_EN
   // K as CSD: 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12 + 2^-14
   function automatic dw_t gain_k(input dw_t v);
      return (v >>> 1) + (v >>> 3) - (v >>> 6)
           - (v >>> 9) - (v >>> 12) + (v >>> 14);
   endfunction

   dw_t  g_x_q, g_y_q;
   logic g_v_q, g_m_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         g_v_q <= 1'b0;
         g_m_q <= 1'b0;
         g_x_q <= '0;
         g_y_q <= '0;
      end else if (!stall) begin
         g_v_q <= sv[STAGES];
         g_m_q <= sm[STAGES];
         g_x_q <= gain_k(sx[STAGES]);
         g_y_q <= gain_k(sy[STAGES]);
      end
   end

   assign f_x = g_x_q;
   assign f_y = g_y_q;
   assign f_v = g_v_q;
   assign f_m = g_m_q;
`else
   assign f_x = sx[STAGES];
   assign f_y = sy[STAGES];
   assign f_v = sv[STAGES];
   assign f_m = sm[STAGES];
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         o_v_q <= 1'b0;
         o_m_q <= 1'b0;
         o_x_q <= '0;
         o_y_q <= '0;
      end else if (!stall) begin
         o_v_q <= f_v;
         o_m_q <= f_m;
         o_x_q <= sat(f_x);
         o_y_q <= sat(f_y);
      end
   end

endmodule

// File: tb/tb_cordic_pipe.sv
// tb_cordic_pipe: directed checks for cordic_pipe.
// WIDTH=20, STAGES=16, no gain compensation.
module tb_cordic_pipe;

   localparam int WIDTH  = 20;
   localparam int STAGES = 16;
   localparam int TOL    = 24;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b0;
   int   errors  = 0;
   int   checks  = 0;

   cordic_pipe_if #(.WIDTH(WIDTH)) bus ();

   cordic_pipe #(
      .WIDTH (WIDTH),
      .STAGES(STAGES)
   ) dut (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .bus    (bus)
   );

   always #5 Clk = ~Clk;

   task automatic drive_idle();
      bus.i_in_valid       = 1'b0;
      bus.i_vectoring_mode = 1'b0;
      bus.i_X              = '0;
      bus.i_Y              = '0;
   endtask

   task automatic send_one(input bit m, input int x,
                           input int y);
      @(posedge Clk); #1;
      bus.i_in_valid       = 1'b1;
      bus.i_vectoring_mode = m;
      bus.i_X              = WIDTH'(x);
      bus.i_Y              = WIDTH'(y);
   endtask

   // edges until o_out_valid, counting the accept edge as 1
   task automatic wait_out(output int n);
      n = -1;
      for (int k = 1; k <= 40 && n < 0; k++) begin
         @(posedge Clk); #1;
         drive_idle();
         @(negedge Clk);
         if (bus.o_out_valid === 1'b1) n = k;
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      drive_idle();
      bus.i_out_ready = 1'b1;
      repeat (3) @(posedge Clk);
      #1 Reset_n = 1'b1;
      @(negedge Clk);
      checks++;
      if (bus.o_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_valid: got %b want 0",
                  bus.o_out_valid);
      end
      checks++;
      if (bus.o_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_ready: got %b want 1",
                  bus.o_in_ready);
      end
      checks++;
      if (bus.o_X !== '0 || bus.o_Y !== '0) begin
         errors++;
         $display("FAIL rst_xy: got %0d,%0d want 0,0",
                  bus.o_X, bus.o_Y);
      end
      checks++;
      if (bus.o_vectoring_mode !== 1'b0) begin
         errors++;
         $display("FAIL rst_mode: got %b want 0",
                  bus.o_vectoring_mode);
      end
   endtask

   task automatic test_vectoring();
      int n;
      send_one(1'b1, 65536, 0);
      wait_out(n);
      checks++;
      if (n !== STAGES + 2) begin
         errors++;
         $display("FAIL vec_latency: got %0d want %0d",
                  n, STAGES + 2);
      end
      checks++;
      if (int'(bus.o_X) > 107922 + TOL ||
          int'(bus.o_X) < 107922 - TOL) begin
         errors++;
         $display("FAIL vec_x: got %0d want 107922",
                  bus.o_X);
      end
      checks++;
      if (int'(bus.o_Y) > TOL || int'(bus.o_Y) < -TOL) begin
         errors++;
         $display("FAIL vec_y: got %0d want 0", bus.o_Y);
      end
      checks++;
      if (bus.o_vectoring_mode !== 1'b1) begin
         errors++;
         $display("FAIL vec_mode: got %b want 1",
                  bus.o_vectoring_mode);
      end
   endtask

   task automatic test_negative_x();
      int n;
      send_one(1'b1, -65536, 0);
      send_one(1'b0, 0, 1000);
      wait_out(n);
      checks++;
      if (n < 0 ||
          int'(bus.o_X) > 107922 + TOL ||
          int'(bus.o_X) < 107922 - TOL ||
          int'(bus.o_Y) > TOL || int'(bus.o_Y) < -TOL) begin
         errors++;
         $display("FAIL negx_vec: got %0d,%0d want 107922,0",
                  bus.o_X, bus.o_Y);
      end
      @(negedge Clk);
      checks++;
      if (bus.o_out_valid !== 1'b1 ||
          bus.o_vectoring_mode !== 1'b0) begin
         errors++;
         $display("FAIL negx_rot_tag: got v=%b m=%b want 1,0",
                  bus.o_out_valid, bus.o_vectoring_mode);
      end
      checks++;
      if (int'(bus.o_X) > TOL || int'(bus.o_X) < -TOL ||
          int'(bus.o_Y) > -1647 + TOL ||
          int'(bus.o_Y) < -1647 - TOL) begin
         errors++;
         $display("FAIL negx_rot: got %0d,%0d want 0,-1647",
                  bus.o_X, bus.o_Y);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      send_one(1'b1, 30000, 40000);
      send_one(1'b0, 0, 50000);
      wait_out(n);
      checks++;
      if (n < 0 ||
          int'(bus.o_X) > 82338 + TOL ||
          int'(bus.o_X) < 82338 - TOL ||
          int'(bus.o_Y) > TOL || int'(bus.o_Y) < -TOL) begin
         errors++;
         $display("FAIL b2b_vec: got %0d,%0d want 82338,0",
                  bus.o_X, bus.o_Y);
      end
      @(negedge Clk);
      checks++;
      if (bus.o_out_valid !== 1'b1 ||
          int'(bus.o_X) > 65870 + TOL ||
          int'(bus.o_X) < 65870 - TOL ||
          int'(bus.o_Y) > 49403 + TOL ||
          int'(bus.o_Y) < 49403 - TOL) begin
         errors++;
         $display("FAIL b2b_rot: got v=%b %0d,%0d want 65870,49403",
                  bus.o_out_valid, bus.o_X, bus.o_Y);
      end
   endtask

   task automatic test_saturation();
      int n;
      send_one(1'b1, 524287, 524287);
      send_one(1'b1, 100000, 0);
      send_one(1'b0, -524288, 524287);
      wait_out(n);
      checks++;
      if (n < 0 || int'(bus.o_X) !== 524287 ||
          int'(bus.o_Y) > TOL || int'(bus.o_Y) < -TOL) begin
         errors++;
         $display("FAIL sat_pos: got %0d,%0d want 524287,0",
                  bus.o_X, bus.o_Y);
      end
      @(negedge Clk);
      checks++;
      if (int'(bus.o_X) > 164676 + TOL ||
          int'(bus.o_X) < 164676 - TOL) begin
         errors++;
         $display("FAIL sat_mid: got %0d want 164676",
                  bus.o_X);
      end
      @(negedge Clk);
      checks++;
      if (int'(bus.o_X) !== -524288 ||
          int'(bus.o_Y) !== 524287) begin
         errors++;
         $display("FAIL sat_rot: got %0d,%0d want -524288,524287",
                  bus.o_X, bus.o_Y);
      end
   endtask

   task automatic test_stall();
      int  tx [20];
      int  ty [20];
      bit  tm [20];
      int  ex [20];
      int  ey [20];
      int  sgn = 1;
      int  in_idx = 0;
      int  out_idx = 0;
      int  extra = 0;
      bit  prev_stall = 1'b0;
      int  prev_x = 0;
      int  prev_y = 0;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) begin
            int a;
            a = ((i % 4) == 0 ? 1 : -1) * (20000 + 1500 * i);
            sgn   = (a < 0) ? -1 : 1;
            tm[i] = 1'b1;
            tx[i] = a;
            ty[i] = 0;
            ex[i] = int'(longint'(sgn * a) * 164676 / 100000);
            ey[i] = 0;
         end else begin
            tm[i] = 1'b0;
            tx[i] = 3000 * i - 20000;
            ty[i] = 25000 - 2000 * i;
            ex[i] = int'(longint'(sgn * tx[i]) * 164676 / 100000);
            ey[i] = int'(longint'(sgn * ty[i]) * 164676 / 100000);
         end
      end
      for (int cyc = 0; cyc < 300 && out_idx < 20; cyc++) begin
         @(posedge Clk); #1;
         bus.i_out_ready = ((cyc % 5) >= 3);
         if (in_idx < 20) begin
            bus.i_in_valid       = 1'b1;
            bus.i_vectoring_mode = tm[in_idx];
            bus.i_X              = WIDTH'(tx[in_idx]);
            bus.i_Y              = WIDTH'(ty[in_idx]);
         end else begin
            drive_idle();
         end
         @(negedge Clk);
         checks++;
         if (bus.o_in_ready !==
             ~(bus.o_out_valid & ~bus.i_out_ready)) begin
            errors++;
            $display("FAIL stall_ready: got %b want %b",
                     bus.o_in_ready,
                     ~(bus.o_out_valid & ~bus.i_out_ready));
         end
         if (prev_stall) begin
            checks++;
            if (bus.o_out_valid !== 1'b1 ||
                int'(bus.o_X) !== prev_x ||
                int'(bus.o_Y) !== prev_y) begin
               errors++;
               $display("FAIL stall_hold: got %0d,%0d want %0d,%0d",
                        bus.o_X, bus.o_Y, prev_x, prev_y);
            end
         end
         prev_stall = bus.o_out_valid & ~bus.i_out_ready;
         prev_x     = int'(bus.o_X);
         prev_y     = int'(bus.o_Y);
         if (bus.o_out_valid && bus.i_out_ready) begin
            checks++;
            if (int'(bus.o_X) > ex[out_idx] + TOL ||
                int'(bus.o_X) < ex[out_idx] - TOL ||
                int'(bus.o_Y) > ey[out_idx] + TOL ||
                int'(bus.o_Y) < ey[out_idx] - TOL ||
                bus.o_vectoring_mode !== tm[out_idx]) begin
               errors++;
               $display("FAIL stall_out%0d: got %0d,%0d m=%b want %0d,%0d m=%b",
                        out_idx, bus.o_X, bus.o_Y,
                        bus.o_vectoring_mode,
                        ex[out_idx], ey[out_idx], tm[out_idx]);
            end
            out_idx++;
         end
         if (bus.i_in_valid && bus.o_in_ready) in_idx++;
      end
      checks++;
      if (out_idx !== 20) begin
         errors++;
         $display("FAIL stall_count: got %0d want 20", out_idx);
      end
      @(posedge Clk); #1;
      bus.i_out_ready = 1'b1;
      drive_idle();
      for (int k = 0; k < 25; k++) begin
         @(negedge Clk);
         if (bus.o_out_valid === 1'b1) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL stall_dup: got %0d extra want 0", extra);
      end
   endtask

   task automatic test_reset_midstream();
      int n;
      bus.i_out_ready = 1'b1;
      for (int k = 0; k < 10; k++)
         send_one(1'b1, 10000 + 1000 * k, 0);
      @(posedge Clk); #1;
      Reset_n = 1'b0;
      drive_idle();
      #1;
      checks++;
      if (bus.o_out_valid !== 1'b0 ||
          bus.o_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_rst: got v=%b r=%b want 0,1",
                  bus.o_out_valid, bus.o_in_ready);
      end
      checks++;
      if (bus.o_X !== '0 || bus.o_Y !== '0 ||
          bus.o_vectoring_mode !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_out: got %0d,%0d m=%b want 0,0,0",
                  bus.o_X, bus.o_Y, bus.o_vectoring_mode);
      end
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      // cleared dirs: every stage turns CCW, net +99.88 deg
      send_one(1'b0, 1000, 0);
      wait_out(n);
      checks++;
      if (n !== STAGES + 2) begin
         errors++;
         $display("FAIL mid_latency: got %0d want %0d",
                  n, STAGES + 2);
      end
      checks++;
      if (int'(bus.o_X) > -283 + TOL ||
          int'(bus.o_X) < -283 - TOL ||
          int'(bus.o_Y) > 1622 + TOL ||
          int'(bus.o_Y) < 1622 - TOL) begin
         errors++;
         $display("FAIL mid_rot: got %0d,%0d want -283,1622",
                  bus.o_X, bus.o_Y);
      end
   endtask

   initial begin
      drive_idle();
      bus.i_out_ready = 1'b1;
      test_reset();
      test_vectoring();
      test_negative_x();
      test_back_to_back();
      test_saturation();
      test_stall();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
